matrix_input_assembler: RTL and testbench
=========================================

Name: matrix_input_assembler

Overview:
- Sits directly downstream of the input validator.
- Takes the user-entered matrix dimensions and the stream of 4-bit elements, gated by the validator's dim/range flags, and counts elements against rows*cols.
- Emits row-major write transactions into matrix storage, plus done/error status for the top-level control FSM.

Parameters:
- MAX_DIM, 5, largest legal row/column count.
- DATA_W, 4, element width in bits.
- ADDR_W, 5, storage address width (holds up to MAX_DIM*MAX_DIM-1).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a new matrix entry.
- abort  input  1  one-cycle pulse that cancels entry from any state.
- end_input  input  1  one-cycle pulse from the user: no more elements.
- input_rows  input  3  requested row count, sampled on start.
- input_cols  input  3  requested column count, sampled on start.
- input_data  input  DATA_W  element value.
- data_valid  input  1  input_data is valid this cycle.
- dim_valid  input  1  validator flag: rows/cols are legal.
- data_range_valid  input  1  validator flag: current element is in range.
- wr_en  output  1  storage write strobe.
- wr_addr  output  ADDR_W  row-major element index.
- wr_data  output  DATA_W  element value to write.
- mat_rows  output  3  latched row count.
- mat_cols  output  3  latched column count.
- elem_count  output  ADDR_W+1  number of elements written so far.
- busy  output  1  high in COLLECT or PAD.
- done  output  1  one-cycle pulse when the matrix is complete.
- err  output  1  level signal, high in ERROR.
- range_drop  output  1  one-cycle pulse when an element is rejected.

Behaviour:
- Reset: all outputs 0; state IDLE; latched dims and count 0. Reset takes effect immediately, including mid-entry. No partial write completes after reset is asserted.
- All outputs are registered. Write latency is 1 cycle: data_valid at cycle N produces wr_en/wr_addr/wr_data at N+1.
- total = mat_rows*mat_cols, computed once when dims are latched, 5-bit unsigned (max 25).
- IDLE:
  - start with dim_valid=1 -> latch rows/cols, clear count, go to COLLECT.
  - start with dim_valid=0 -> go to ERROR.
  - data_valid and end_input are ignored.
- COLLECT:
  - data_valid & data_range_valid -> write at wr_addr=count, then count+1.
  - data_valid & !data_range_valid -> no write; range_drop pulses; count unchanged.
  - When the accepted element brings count to total -> DONE.
  - end_input with count<total -> PAD (if the optional feature is enabled) or ERROR.
  - end_input with count==total cannot occur, because the block has already left COLLECT.
  - start is ignored.
- PAD: writes wr_data=0 at successive addresses, one per cycle, until count==total, then DONE. Inputs other than abort are ignored.
- DONE: done=1 for exactly one cycle, then IDLE. mat_rows, mat_cols and elem_count hold their values until the next start.
- ERROR: err=1 and no writes. start with dim_valid=1 restarts directly into COLLECT; abort -> IDLE.
- abort from any state -> IDLE on the next edge. abort beats a simultaneous data_valid or end_input (no write). count is cleared.
- data_valid arriving in the same cycle the last element is accepted is impossible by construction. Data arriving in DONE or IDLE is dropped silently, with no range_drop.
- data_valid and end_input in the same cycle: the element is processed first, then end_input is evaluated against the updated count.

Optional Feature:
- Macro: MATRIX_PAD_ZERO_EN.
- Defined: early end_input goes to PAD and the matrix is zero-filled to total, ending in a done pulse.
- Undefined: PAD state is absent; early end_input goes to ERROR and no done pulse is issued.

Decomposition:
- Shared package matrix_pkg holds:
  - state enum (IDLE, COLLECT, PAD, DONE, ERROR);
  - MAX_DIM, DATA_W, ADDR_W constants;
  - the MAX_ELEMS=25 constant.
- No sub-module: a single FSM with a counter is natural. The rows*cols product is inline combinational logic, registered at latch time.

Test Plan:
- Normal entry: start with rows=2, cols=3, dim_valid=1, then 6 valid elements 1..6 -> wr_addr 0..5 carrying data 1..6, each 1 cycle after its data_valid; done pulse once; elem_count=6.
- Bad dims: start with dim_valid=0 -> err=1, no wr_en. A subsequent start with a valid 1x1 dim and one element -> done.
- Range reject: in a 2x2 entry, the third element arrives with data_range_valid=0 -> range_drop pulse, no write, count stays 2. Two further valid elements -> addresses 2 and 3, then done.
- Early end, MATRIX_PAD_ZERO_EN defined: 3x3 entry, 4 elements, then end_input -> zero writes at addresses 4..8 on consecutive cycles, then done. Macro undefined: same stimulus -> err=1 and no writes after address 3.
- Abort vs. data: abort and data_valid in the same cycle mid-entry -> no wr_en, state IDLE, elem_count=0.
- Reset mid-entry: assert rst_n=0 after 2 of 4 elements -> all outputs 0 immediately. After release, data_valid produces no writes until the next start.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and write payload for the matrix input assembler.
package matrix_pkg;

    localparam int unsigned MAX_DIM   = 5;
    localparam int unsigned DATA_W    = 4;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DIM_W     = 3;
    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned MAX_ELEMS = MAX_DIM * MAX_DIM;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        PAD,
        DONE,
        ERROR
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_txn_t;

    // rows*cols, saturated at the largest storable matrix
    function automatic logic [ADDR_W-1:0] elem_total(input logic [DIM_W-1:0] rows,
                                                     input logic [DIM_W-1:0] cols);
        logic [2*DIM_W-1:0] prod;
        prod = (2*DIM_W)'(rows) * (2*DIM_W)'(cols);
        if (prod > (2*DIM_W)'(MAX_ELEMS)) begin
            return ADDR_W'(MAX_ELEMS);
        end
        return ADDR_W'(prod);
    endfunction

endpackage

// File: rtl/matrix_input_assembler_if.sv
// Control, element stream and storage-write/status bundle of the matrix input assembler.
interface matrix_input_assembler_if;
    import matrix_pkg::*;

    logic              start;
    logic              abort;
    logic              end_input;
    logic [DIM_W-1:0]  input_rows;
    logic [DIM_W-1:0]  input_cols;
    logic [DATA_W-1:0] input_data;
    logic              data_valid;
    logic              dim_valid;
    logic              data_range_valid;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DIM_W-1:0]  mat_rows;
    logic [DIM_W-1:0]  mat_cols;
    logic [CNT_W-1:0]  elem_count;
    logic              busy;
    logic              done;
    logic              err;
    logic              range_drop;

    modport master (
        output start, abort, end_input, input_rows, input_cols, input_data,
               data_valid, dim_valid, data_range_valid,
        input  wr_en, wr_addr, wr_data, mat_rows, mat_cols, elem_count,
               busy, done, err, range_drop
    );

    modport slave (
        input  start, abort, end_input, input_rows, input_cols, input_data,
               data_valid, dim_valid, data_range_valid,
        output wr_en, wr_addr, wr_data, mat_rows, mat_cols, elem_count,
               busy, done, err, range_drop
    );

endinterface

// File: rtl/matrix_input_assembler.sv
// Counts validated elements against rows*cols and emits row-major storage writes.
// Build option MATRIX_PAD_ZERO_EN: early end_input zero-fills the matrix instead of erroring.
module matrix_input_assembler
    import matrix_pkg::*;
(
    input logic                     clk,
    input logic                     rst_n,
    matrix_input_assembler_if.slave bus
);

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic [ADDR_W-1:0] total_q, total_d;
    logic [CNT_W-1:0]  count_q, count_d;
    wr_txn_t           wr_q, wr_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              range_drop_q, range_drop_d;

    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  total_ext;

    assign count_inc = count_q + CNT_W'(1);
    assign total_ext = CNT_W'(total_q);

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rows_q       <= '0;
            cols_q       <= '0;
            total_q      <= '0;
            count_q      <= '0;
            wr_q         <= '0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            range_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            total_q      <= total_d;
            count_q      <= count_d;
            wr_q         <= wr_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            range_drop_q <= range_drop_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        total_d      = total_q;
        count_d      = count_q;
        wr_d         = '0;
        wr_en_d      = 1'b0;
        range_drop_d = 1'b0;

        case (state_q)
            IDLE, ERROR: begin
                if (bus.start && bus.dim_valid) begin
                    rows_d  = bus.input_rows;
                    cols_d  = bus.input_cols;
                    total_d = elem_total(bus.input_rows, bus.input_cols);
                    count_d = '0;
                    state_d = COLLECT;
                end else if (bus.start) begin
                    state_d = ERROR;
                end
            end

            COLLECT: begin
                if (bus.data_valid && bus.data_range_valid) begin
                    wr_en_d      = 1'b1;
                    wr_d.addr    = ADDR_W'(count_q);
                    wr_d.data    = bus.input_data;
                    count_d      = count_inc;
                end else if (bus.data_valid) begin
                    range_drop_d = 1'b1;
                end
                // The element is accounted for before end_input is judged
                if (count_d == total_ext) begin
                    state_d = DONE;
                end else if (bus.end_input) begin
`ifdef MATRIX_PAD_ZERO_EN
                    state_d = PAD;
`else
                    state_d = ERROR;
`endif
                end
            end

`ifdef MATRIX_PAD_ZERO_EN
            PAD: begin
                wr_en_d   = 1'b1;
                wr_d.addr = ADDR_W'(count_q);
                wr_d.data = '0;
                count_d   = count_inc;
                if (count_inc == total_ext) begin
                    state_d = DONE;
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // abort wins over anything else seen in the same cycle
        if (bus.abort) begin
            state_d      = IDLE;
            count_d      = '0;
            wr_d         = '0;
            wr_en_d      = 1'b0;
            range_drop_d = 1'b0;
        end

        busy_d = (state_d == COLLECT) || (state_d == PAD);
        done_d = (state_d == DONE);
        err_d  = (state_d == ERROR);
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_q.addr;
    assign bus.wr_data    = wr_q.data;
    assign bus.mat_rows   = rows_q;
    assign bus.mat_cols   = cols_q;
    assign bus.elem_count = count_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.range_drop = range_drop_q;

endmodule

// File: tb/tb_matrix_input_assembler.sv
// Scoreboard bench for matrix_input_assembler: directed scenarios followed by random traffic.
module tb_matrix_input_assembler;

`ifdef MATRIX_PAD_ZERO_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_PAD     = 2;
    localparam int M_DONE    = 3;
    localparam int M_ERR     = 4;

    typedef struct packed {
        logic       wr_en;
        logic       busy;
        logic       done;
        logic       err;
        logic       range_drop;
        logic [5:0] elem_count;
        logic [2:0] mat_rows;
        logic [2:0] mat_cols;
    } snap_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [3:0] data;
    } wr_t;

    logic clk;
    logic rst_n;

    matrix_input_assembler_if bus();

    matrix_input_assembler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    done_seen = 0;
    snap_t sq[$];
    wr_t   wq[$];

    // Reference: one matrix-entry session described in terms of the entry rules
    int m_mode  = M_IDLE;
    int m_count = 0;
    int m_total = 0;
    int m_rows  = 0;
    int m_cols  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit st, input bit ab, input bit en, input int r, input int c,
                         input int d, input bit dv, input bit dimv, input bit rv);
        bit    wr = 1'b0;
        bit    rd = 1'b0;
        snap_t s;
        if (ab) begin
            m_mode  = M_IDLE;
            m_count = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_ERR: begin
                    if (st && dimv) begin
                        m_rows  = r;
                        m_cols  = c;
                        m_total = r * c;
                        m_count = 0;
                        m_mode  = M_COLLECT;
                    end else if (st) begin
                        m_mode = M_ERR;
                    end
                end
                M_COLLECT: begin
                    if (dv && rv) begin
                        wq.push_back(wr_t'{5'(m_count), 4'(d)});
                        m_count++;
                        wr = 1'b1;
                    end else if (dv) begin
                        rd = 1'b1;
                    end
                    if (m_count == m_total) m_mode = M_DONE;
                    else if (en) m_mode = PAD_EN ? M_PAD : M_ERR;
                end
                M_PAD: begin
                    wq.push_back(wr_t'{5'(m_count), 4'd0});
                    m_count++;
                    wr = 1'b1;
                    if (m_count == m_total) m_mode = M_DONE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
        s = '{wr, (m_mode == M_COLLECT) || (m_mode == M_PAD), m_mode == M_DONE,
              m_mode == M_ERR, rd, 6'(m_count), 3'(m_rows), 3'(m_cols)};
        sq.push_back(s);
    endtask

    // Drive one cycle of inputs; the expectation for the following edge is queued
    task automatic step(input bit st, input bit ab, input bit en, input int r, input int c,
                        input int d, input bit dv, input bit dimv, input bit rv);
        bus.start            = st;
        bus.abort            = ab;
        bus.end_input        = en;
        bus.input_rows       = 3'(r);
        bus.input_cols       = 3'(c);
        bus.input_data       = 4'(d);
        bus.data_valid       = dv;
        bus.dim_valid        = dimv;
        bus.data_range_valid = rv;
        @(posedge clk);
        model(st, ab, en, r, c, d, dv, dimv, rv);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic begin_mat(input int r, input int c, input bit dimv);
        step(1, 0, 0, r, c, 0, 0, dimv, 0);
    endtask

    task automatic elem(input int d, input bit rv);
        step(0, 0, 0, 0, 0, d, 1, 0, rv);
    endtask

    function automatic int all_outputs();
        return int'({bus.wr_en, bus.wr_addr, bus.wr_data, bus.mat_rows, bus.mat_cols,
                     bus.elem_count, bus.busy, bus.done, bus.err, bus.range_drop} != 0);
    endfunction

    // Monitor: compare status every cycle, pop a write expectation whenever the DUT writes
    initial begin
        snap_t act_s;
        snap_t exp_s;
        wr_t   exp_w;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                exp_s = sq.pop_front();
                act_s = '{bus.wr_en, bus.busy, bus.done, bus.err, bus.range_drop,
                          bus.elem_count, bus.mat_rows, bus.mat_cols};
                checks++;
                if (act_s != exp_s) begin
                    errors++;
                    $display("FAIL status t=%0t actual=%h required=%h", $time, act_s, exp_s);
                end
            end
            if (rst_n && bus.wr_en) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected t=%0t actual=%0d/%0d required=none",
                             $time, bus.wr_addr, bus.wr_data);
                end else begin
                    exp_w = wq.pop_front();
                    if ({bus.wr_addr, bus.wr_data} != exp_w) begin
                        errors++;
                        $display("FAIL write t=%0t actual=%0d/%0d required=%0d/%0d",
                                 $time, bus.wr_addr, bus.wr_data, exp_w.addr, exp_w.data);
                    end
                end
            end
            if (bus.done) done_seen++;
        end
    end

    initial begin
        int d0;
        rst_n                = 1'b0;
        bus.start            = 1'b0;
        bus.abort            = 1'b0;
        bus.end_input        = 1'b0;
        bus.input_rows       = '0;
        bus.input_cols       = '0;
        bus.input_data       = '0;
        bus.data_valid       = 1'b0;
        bus.dim_valid        = 1'b0;
        bus.data_range_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 0);
        rst_n = 1'b1;
        idle();

        // Normal 2x3 entry
        d0 = done_seen;
        begin_mat(2, 3, 1);
        for (int i = 1; i <= 6; i++) elem(i, 1);
        idle();
        idle();
        check("normal_count", int'(bus.elem_count), 6);
        check("normal_done_once", done_seen - d0, 1);

        // Bad dims, then recovery from ERROR with a 1x1 matrix
        begin_mat(3, 3, 0);
        check("bad_dims_err", int'(bus.err), 1);
        d0 = done_seen;
        begin_mat(1, 1, 1);
        elem(9, 1);
        idle();
        idle();
        check("recover_done", done_seen - d0, 1);

        // Range reject inside a 2x2 entry
        begin_mat(2, 2, 1);
        elem(3, 1);
        elem(4, 1);
        elem(15, 0);
        check("range_drop_pulse", int'(bus.range_drop), 1);
        check("range_count_held", int'(bus.elem_count), 2);
        elem(5, 1);
        elem(6, 1);
        idle();
        idle();

        // Early end_input on a 3x3 entry
        d0 = done_seen;
        begin_mat(3, 3, 1);
        for (int i = 0; i < 4; i++) elem(i + 7, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (7) idle();
        if (PAD_EN) begin
            check("pad_count", int'(bus.elem_count), 9);
            check("pad_done", done_seen - d0, 1);
        end else begin
            check("early_end_err", int'(bus.err), 1);
            check("early_end_count", int'(bus.elem_count), 4);
            step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        end

        // abort together with data mid-entry
        begin_mat(3, 3, 1);
        elem(1, 1);
        elem(2, 1);
        step(0, 1, 0, 0, 0, 11, 1, 0, 1);
        check("abort_no_write", int'(bus.wr_en), 0);
        check("abort_count", int'(bus.elem_count), 0);
        check("abort_idle", int'(bus.busy), 0);

        // Reset mid-entry
        begin_mat(2, 2, 1);
        elem(1, 1);
        elem(2, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", all_outputs(), 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_mode  = M_IDLE;
        m_count = 0;
        m_total = 0;
        m_rows  = 0;
        m_cols  = 0;
        for (int i = 0; i < 3; i++) elem(i + 1, 1);
        check("post_reset_no_write", int'(bus.wr_en), 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            int c;
            bit dimv;
            dimv = ($urandom_range(0, 9) != 0);
            if (dimv) begin
                r = int'($urandom_range(1, 5));
                c = int'($urandom_range(1, 5));
            end else begin
                r = int'($urandom_range(0, 7));
                c = int'($urandom_range(0, 7));
            end
            step($urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 29) == 0, r, c, int'($urandom_range(0, 15)),
                 $urandom_range(0, 2) != 0, dimv, $urandom_range(0, 6) != 0);
        end

        repeat (3) idle();
        @(negedge clk);
        #1;
        check("write_queue_drained", wq.size(), 0);
        check("status_queue_drained", sq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
